cp0_unit: RTL and testbench

- Coprocessor-0 for the P7 MIPS pipeline. Holds SR, Cause, EPC and PRId.
- Detects interrupts and exceptions at the M-stage macro-PC and asserts Req, which the next-PC logic uses to redirect fetch to 0x00004180.
- Supplies EPC for eret. Serves mfc0/mtc0.
- Req is combinational. All architectural state updates on the rising clk edge.

---
 rtl/cp0_unit_if.sv | 26 ++
 rtl/cp0_unit.sv | 115 +++++++++++
 tb/tb_cp0_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_unit_if.sv
// Pipeline-to-CP0 signal bundle: mfc0/mtc0 access, victim-instruction info,
// interrupt lines, and the exception request/EPC returned to next-PC logic.
interface cp0_unit_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        We;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] Dout;

    modport master (
        output A1, A2, Din, We, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  Req, EPCOut, Dout
    );

    modport slave (
        input  A1, A2, Din, We, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output Req, EPCOut, Dout
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId storage, M-stage interrupt and exception
// detection, and mfc0/mtc0 access.
module cp0_unit #(
    parameter logic [31:0] PRID_VAL   = 32'h20210000,
    parameter logic [31:0] HANDLER_PC = 32'h00004180
) (
    input  logic      clk,
    input  logic      reset,
    cp0_unit_if.slave bus
);
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // The handler address is consumed by the next-PC logic, not here.
    logic [31:0] unused_handler_pc;
    assign unused_handler_pc = HANDLER_PC;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic [5:0]  irq_pend;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] dout;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_irq
            assign irq_pend[gi] = bus.HWInt[gi] & im_q[gi];
        end
    endgenerate

    assign int_req = ie_q & ~exl_q & (|irq_pend);
    assign exc_req = (bus.ExcCodeIn != 5'd0) & ~exl_q;
    assign req     = int_req | exc_req;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = bus.HWInt;

        if (req) begin
            // Taking the trap swallows any mtc0 or eret in the same cycle.
            exl_d      = 1'b1;
            bd_d       = bus.BDIn;
            epc_d      = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
            exc_code_d = int_req ? 5'd0 : bus.ExcCodeIn;
        end else begin
            if (bus.We && (bus.A2 == REG_SR)) begin
                im_d  = bus.Din[15:10];
                exl_d = bus.Din[1];
                ie_d  = bus.Din[0];
            end
            if (bus.We && (bus.A2 == REG_EPC)) begin
                epc_d = bus.Din;
            end
            // eret wins over an mtc0 SR write on the EXL bit.
            if (bus.EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

    always_comb begin
        dout = 32'd0;
        case (bus.A1)
            REG_SR:    dout = sr_word;
            REG_CAUSE: dout = cause_word;
            REG_EPC:   dout = epc_q;
            REG_PRID:  dout = PRID_VAL;
            default:   dout = 32'd0;
        endcase
    end

    assign bus.Req    = req;
    assign bus.EPCOut = epc_q;
    assign bus.Dout   = dout;
endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed vector table with hand-derived expectations,
// then randomized traffic checked against a register-word reference model.
module tb_cp0_unit;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    cp0_unit_if bus();

    cp0_unit dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  a1;
        logic        we;
        logic [4:0]  a2;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        exp_req;
        logic [31:0] exp_dout;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vq[$];

    // Reference model: architectural registers held as whole words.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    function automatic vec_t mk(input logic r, input logic [4:0] a1, input logic we,
                                input logic [4:0] a2, input logic [31:0] din,
                                input logic [31:0] vpc, input logic bd,
                                input logic [4:0] exc, input logic [5:0] hw,
                                input logic clr, input logic req,
                                input logic [31:0] dout, input logic [31:0] epc);
        vec_t v;
        v.rst = r;  v.a1 = a1; v.we = we; v.a2 = a2; v.din = din; v.vpc = vpc;
        v.bd = bd;  v.exc = exc; v.hw = hw; v.clr = clr;
        v.exp_req = req; v.exp_dout = dout; v.exp_epc = epc;
        return v;
    endfunction

    function automatic logic model_int();
        return m_sr[0] && !m_sr[1] && ((bus.HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic model_req();
        return model_int() || ((bus.ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_dout(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h20210000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] code;
        logic [31:0] ipw;
        ipw = 32'(bus.HWInt) << 10;
        if (rst) begin
            m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        end else if (model_req()) begin
            code    = model_int() ? 32'd0 : 32'(bus.ExcCodeIn);
            m_epc   = bus.VPC - (bus.BDIn ? 32'd4 : 32'd0);
            m_sr    = m_sr | 32'h2;
            m_cause = (32'(bus.BDIn) << 31) | ipw | (code << 2);
        end else begin
            if (bus.We && bus.A2 == 5'd12) m_sr = bus.Din & 32'h0000FC03;
            if (bus.We && bus.A2 == 5'd14) m_epc = bus.Din;
            if (bus.EXLClr) m_sr = m_sr & ~32'h2;
            m_cause = (m_cause & ~32'h0000FC00) | ipw;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.A1        = v.a1;
        bus.We        = v.we;
        bus.A2        = v.a2;
        bus.Din       = v.din;
        bus.VPC       = v.vpc;
        bus.BDIn      = v.bd;
        bus.ExcCodeIn = v.exc;
        bus.HWInt     = v.hw;
        bus.EXLClr    = v.clr;
    endtask

    task automatic apply_row(input string tag, input int idx, input vec_t v);
        drive(v);
        #1;
        $display("[TB] %s %0d a1=%0d req=%0b dout=%h epc=%h", tag, idx, v.a1,
                 bus.Req, bus.Dout, bus.EPCOut);
        check($sformatf("%s%0d_req", tag, idx), 32'(bus.Req), 32'(v.exp_req));
        check($sformatf("%s%0d_dout", tag, idx), bus.Dout, v.exp_dout);
        check($sformatf("%s%0d_epc", tag, idx), bus.EPCOut, v.exp_epc);
        tick();
    endtask

    initial begin
        vec_t v;
        n_tests = 0;
        n_fail  = 0;
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();

        //     rst a1  we a2  din            vpc            bd exc hw     clr req dout            epc
        vq.push_back(mk(0, 12, 0, 0,  0,             0,             0, 0,  6'h00, 0, 0, 32'h0,        32'h0));
        vq.push_back(mk(0, 13, 0, 0,  0,             0,             0, 0,  6'h00, 0, 0, 32'h0,        32'h0));
        vq.push_back(mk(0, 14, 0, 0,  0,             0,             0, 0,  6'h00, 0, 0, 32'h0,        32'h0));
        vq.push_back(mk(0, 15, 0, 0,  0,             0,             0, 0,  6'h00, 0, 0, 32'h20210000, 32'h0));
        vq.push_back(mk(0, 12, 1, 12, 32'h401,       0,             0, 0,  6'h00, 0, 0, 32'h0,        32'h0));
        vq.push_back(mk(0, 12, 0, 0,  0,             32'h3010,      0, 0,  6'h01, 0, 1, 32'h401,      32'h0));
        vq.push_back(mk(0, 13, 0, 0,  0,             0,             0, 0,  6'h01, 0, 0, 32'h400,      32'h3010));
        vq.push_back(mk(0, 12, 1, 12, 32'h403,       0,             0, 0,  6'h01, 1, 0, 32'h403,      32'h3010));
        vq.push_back(mk(0, 12, 0, 0,  0,             32'h3100,      0, 0,  6'h01, 0, 1, 32'h401,      32'h3010));
        vq.push_back(mk(1, 14, 0, 0,  0,             0,             0, 0,  6'h01, 0, 0, 32'h3100,     32'h3100));
        vq.push_back(mk(0, 12, 0, 0,  0,             0,             0, 0,  6'h01, 0, 0, 32'h0,        32'h0));
        vq.push_back(mk(0, 13, 0, 0,  0,             0,             0, 0,  6'h00, 0, 0, 32'h400,      32'h0));
        vq.push_back(mk(0, 13, 1, 12, 32'h1,         0,             0, 0,  6'h00, 0, 0, 32'h0,        32'h0));
        vq.push_back(mk(0, 12, 0, 0,  0,             32'h3024,      1, 12, 6'h00, 0, 1, 32'h1,        32'h0));
        vq.push_back(mk(0, 13, 1, 12, 32'h401,       0,             0, 0,  6'h00, 0, 0, 32'h80000030, 32'h3020));
        vq.push_back(mk(0, 14, 1, 14, 32'h12345678,  32'h3040,      0, 4,  6'h01, 0, 1, 32'h3020,     32'h3020));
        vq.push_back(mk(0, 14, 0, 0,  0,             0,             0, 0,  6'h00, 0, 0, 32'h3040,     32'h3040));
        vq.push_back(mk(0, 13, 0, 0,  0,             0,             0, 5,  6'h3F, 0, 0, 32'h0,        32'h3040));
        vq.push_back(mk(0, 13, 0, 0,  0,             0,             0, 0,  6'h00, 1, 0, 32'hFC00,     32'h3040));
        vq.push_back(mk(0, 12, 0, 0,  0,             0,             1, 8,  6'h00, 0, 1, 32'h401,      32'h3040));
        vq.push_back(mk(0, 13, 0, 0,  0,             0,             0, 0,  6'h00, 0, 0, 32'h80000020, 32'hFFFFFFFC));
        vq.push_back(mk(0, 15, 1, 13, 32'hFFFFFFFF,  0,             0, 0,  6'h00, 1, 0, 32'h20210000, 32'hFFFFFFFC));
        vq.push_back(mk(0, 13, 0, 0,  0,             0,             0, 0,  6'h00, 0, 0, 32'h80000020, 32'hFFFFFFFC));
        vq.push_back(mk(0, 7,  1, 12, 32'h0000FC00,  0,             0, 0,  6'h00, 0, 0, 32'h0,        32'hFFFFFFFC));
        vq.push_back(mk(0, 12, 0, 0,  0,             0,             0, 0,  6'h3F, 0, 0, 32'hFC00,     32'hFFFFFFFC));
        vq.push_back(mk(0, 13, 0, 0,  0,             0,             0, 0,  6'h00, 0, 0, 32'h8000FC20, 32'hFFFFFFFC));

        foreach (vq[i]) apply_row("vec", i, vq[i]);

        // No write-to-read bypass on EPC across a reset boundary.
        apply_row("seq", 0, mk(1, 14, 0, 0,  0,            0, 0, 0, 6'h00, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC));
        apply_row("seq", 1, mk(0, 14, 1, 14, 32'hCAFEF00C, 0, 0, 0, 6'h00, 0, 0, 32'h0,        32'h0));
        apply_row("seq", 2, mk(0, 14, 1, 15, 32'h11111111, 0, 0, 0, 6'h00, 0, 0, 32'hCAFEF00C, 32'hCAFEF00C));
        apply_row("seq", 3, mk(0, 15, 0, 0,  0,            0, 0, 0, 6'h00, 0, 0, 32'h20210000, 32'hCAFEF00C));

        for (int i = 0; i < 400; i++) begin
            v.rst = ($urandom_range(0, 39) == 0);
            v.a1  = 5'($urandom_range(10, 16));
            v.we  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0:       v.a2 = 5'd12;
                1:       v.a2 = 5'd13;
                2:       v.a2 = 5'd14;
                3:       v.a2 = 5'd15;
                default: v.a2 = 5'($urandom);
            endcase
            v.din = $urandom;
            v.vpc = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            v.bd  = 1'($urandom_range(0, 1));
            v.exc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            v.hw  = 6'($urandom);
            v.clr = ($urandom_range(0, 4) == 0);
            drive(v);
            #1;
            v.exp_req  = model_req();
            v.exp_dout = model_dout(v.a1);
            v.exp_epc  = m_epc;
            $display("[TB] rnd %0d a1=%0d req=%0b dout=%h epc=%h", i, v.a1,
                     bus.Req, bus.Dout, bus.EPCOut);
            check($sformatf("rnd%0d_req", i), 32'(bus.Req), 32'(v.exp_req));
            check($sformatf("rnd%0d_dout", i), bus.Dout, v.exp_dout);
            check($sformatf("rnd%0d_epc", i), bus.EPCOut, v.exp_epc);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
